trig_arbiter: RTL

- Time-shares one sin_cos lookup (registered ROM, phase in, signed 18-bit sin/cos out) between NUM_REQ rotating-sprite requesters: ship, asteroids and bullets.
- Round-robin arbitration; one lookup issued per cycle.
- Tracks in-flight lookups through the sin_cos latency and stores each requester's last result in a private register.
- Sits between the object units and the single sin_cos instance.

---
 rtl/trig_pkg.sv | 22 ++
 rtl/rr_pick.sv | 37 +++
 rtl/trig_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// Shared types and defaults for the sin/cos lookup arbiter.
package trig_pkg;

    localparam int TRIG_W_DEF  = 18;
    localparam int PHASE_W_DEF = 10;

    // Requester ids travel through the in-flight pipeline as 3 bits (up to 8 requesters).
    localparam int ID_W = 3;

    typedef logic signed [TRIG_W_DEF-1:0] trig_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } trig_tag_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first eligible requester at or after ptr, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);

    int ptr_int;
    int off;
    int best_off;

    // Each candidate gets its wrapped distance from ptr; the smallest eligible distance wins.
    always_comb begin
        winner   = '0;
        any      = 1'b0;
        ptr_int  = int'(ptr);
        off      = 0;
        best_off = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i >= ptr_int) begin
                off = i - ptr_int;
            end else begin
                off = i + NUM_REQ - ptr_int;
            end
            if (eligible[i] && (off < best_off)) begin
                best_off = off;
                winner   = PTR_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trig_arbiter.sv
// Time-shares one registered sin_cos lookup between NUM_REQ sprite requesters.
// One lookup is issued per cycle in round-robin order; each requester's id rides
// a tag pipeline alongside the lookup so the returning sin/cos lands in that
// requester's private result register, with a one-cycle done pulse.
//
// Handshake: req is a level. A requester is eligible while req is high and it has
// no lookup outstanding. gnt pulses for exactly one cycle when its phase has been
// captured; after that edge the requester may change phase_in or drop req freely.
// done pulses for one cycle when its result register has just been written, and
// the requester is eligible again in that same cycle.
module trig_arbiter
    import trig_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int TRIG_W  = TRIG_W_DEF,
    parameter int LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*PHASE_W-1:0] phase_in,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [PHASE_W-1:0]      trig_phase,
    input  logic [TRIG_W-1:0]       trig_sin,
    input  logic [TRIG_W-1:0]       trig_cos,
    output logic [NUM_REQ-1:0]      done,
    output logic [NUM_REQ*TRIG_W-1:0] sin_out,
    output logic [NUM_REQ*TRIG_W-1:0] cos_out,
    output logic                    busy
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    // Registered state
    logic [NUM_REQ-1:0]        gnt_q,        gnt_d;
    logic [NUM_REQ-1:0]        done_q,       done_d;
    logic [PHASE_W-1:0]        trig_phase_q, trig_phase_d;
    logic [NUM_REQ-1:0]        pending_q,    pending_d;
    logic [PTR_W-1:0]          ptr_q,        ptr_d;
    logic                      busy_q,       busy_d;
    logic [NUM_REQ*TRIG_W-1:0] sin_q,        sin_d;
    logic [NUM_REQ*TRIG_W-1:0] cos_q,        cos_d;

    // tag_q[0] is loaded at the issue edge together with trig_phase; the following
    // LATENCY stages follow the lookup through sin_cos, so tag_q[LATENCY] names
    // the owner of the trig_sin/trig_cos presented this cycle.
    trig_tag_t tag_q [0:LATENCY];
    trig_tag_t tag_d [0:LATENCY];

    // Arbitration signals
    logic [NUM_REQ-1:0] eligible;
    logic [PTR_W-1:0]   winner;
    logic               any;
    logic [PHASE_W-1:0] phase_sel;
    logic [NUM_REQ-1:0] issue_mask;
    logic [NUM_REQ-1:0] retire_mask;
    logic [PTR_W-1:0]   ptr_next;
    trig_tag_t          retire_tag;

    assign eligible = req & ~pending_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .winner   (winner),
        .any      (any)
    );

    // Phase mux for the winning requester and the pointer step past it.
    always_comb begin
        phase_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                phase_sel = phase_in[i*PHASE_W +: PHASE_W];
            end
        end
        if (winner == PTR_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = winner + 1'b1;
        end
    end

    // One-hot masks for this cycle's issue and retirement.
    always_comb begin
        retire_tag  = tag_q[LATENCY];
        issue_mask  = '0;
        retire_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            issue_mask[i]  = any && (winner == PTR_W'(i));
            retire_mask[i] = retire_tag.valid && (retire_tag.id == ID_W'(i));
        end
    end

    // Next-state: issue, tag shift, retirement into the per-requester result registers.
    always_comb begin
        gnt_d        = issue_mask;
        done_d       = retire_mask;
        pending_d    = (pending_q & ~retire_mask) | issue_mask;
        busy_d       = |pending_q;
        trig_phase_d = any ? phase_sel : trig_phase_q;
        ptr_d        = any ? ptr_next : ptr_q;

        tag_d[0].valid = any;
        tag_d[0].id    = any ? ID_W'(winner) : '0;
        for (int s = 1; s <= LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        sin_d = sin_q;
        cos_d = cos_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (retire_mask[i]) begin
                sin_d[i*TRIG_W +: TRIG_W] = trig_sin;
                cos_d[i*TRIG_W +: TRIG_W] = trig_cos;
            end
        end
    end

    // State registers; reset discards everything in flight and clears stored results.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            gnt_q        <= '0;
            done_q       <= '0;
            trig_phase_q <= '0;
            pending_q    <= '0;
            ptr_q        <= '0;
            busy_q       <= 1'b0;
            sin_q        <= '0;
            cos_q        <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            trig_phase_q <= trig_phase_d;
            pending_q    <= pending_d;
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            sin_q        <= sin_d;
            cos_q        <= cos_d;
            for (int s = 0; s <= LATENCY; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign trig_phase = trig_phase_q;
    assign busy       = busy_q;
    assign sin_out    = sin_q;
    assign cos_out    = cos_q;

endmodule
